// File: rtl/ysyx_22050518_pipe_addsub.sv
// ysyx_22050518_pipe_addsub
// Pipelined adder/subtractor with a valid/ready handshake on both sides.
// The carry chain is cut into STAGES equal chunks; each stage resolves one
// chunk using the carry registered by the stage before it. Unresolved upper
// operand chunks ride along in shrinking stage registers, and the already
// resolved lower result chunks ride along in growing skew registers, so the
// last stage holds the full result together with its flags.
//
// Parameters
//   WIDTH     operand/result width, must be a multiple of STAGES
//   STAGES    number of pipeline stages (>= 1), also the latency in cycles
// Ports
//   clk       clock, everything updates on the rising edge
//   rst_n     synchronous active-low reset
//   in_valid  operand set offered          in_ready  operand set can be taken
//   in1, in2  operands                     c_in      carry-in / borrow-in
//   sub       0 = add, 1 = subtract
//   out_valid result valid                 out_ready consumer takes the result
//   out       result                       c_out     carry out of the MSB
//   ovf       signed overflow              zero      result is all zeros
module ysyx_22050518_pipe_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = WIDTH / STAGES;

    logic             en;
    logic [WIDTH-1:0] opB;
    logic             carryIn;

    // The whole pipeline moves as one: it advances whenever the output slot
    // is empty or being drained, and otherwise freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtraction is folded into addition of the inverted operand with an
    // inverted carry, so in1 - in2 - c_in == in1 + ~in2 + !c_in.
    assign opB     = sub ? ~in2 : in2;
    assign carryIn = sub ? ~c_in : c_in;

    for (genvar g = 0; g < STAGES; g++) begin : gStage
        // Operand bits still unresolved when entering this stage, and the
        // number of result bits known after it.
        localparam int SRCW = WIDTH - g * CW;
        localparam int RESW = (g + 1) * CW;

        logic [SRCW-1:0] srcA;
        logic [SRCW-1:0] srcB;
        logic            srcC;
        logic            srcV;
        logic            srcAMsb;
        logic            srcBMsb;
        logic [CW:0]     sum;
        logic [RESW-1:0] res_d;
        logic [RESW-1:0] res_q;
        logic            valid_q;
        logic            carry_q;

        // Stage 0 is fed straight from the ports; later stages take the
        // leftover operands, carry and partial result of the previous stage.
        if (g == 0) begin : gSrc
            assign srcA    = in1;
            assign srcB    = opB;
            assign srcC    = carryIn;
            assign srcV    = in_valid;
            assign srcAMsb = in1[WIDTH-1];
            assign srcBMsb = opB[WIDTH-1];
            assign res_d   = sum[CW-1:0];
        end else begin : gSrc
            assign srcA    = gStage[g-1].gOps.opA_q;
            assign srcB    = gStage[g-1].gOps.opB_q;
            assign srcC    = gStage[g-1].carry_q;
            assign srcV    = gStage[g-1].valid_q;
            assign srcAMsb = gStage[g-1].gOps.aMsb_q;
            assign srcBMsb = gStage[g-1].gOps.bMsb_q;
            assign res_d   = {sum[CW-1:0], gStage[g-1].res_q};
        end

        // Only the lowest remaining chunk is resolved here; its carry-out is
        // what the next stage will consume one edge later.
        assign sum = {1'b0, srcA[CW-1:0]} + {1'b0, srcB[CW-1:0]} + {{CW{1'b0}}, srcC};

        // Valid bit, chunk carry and the skewed partial result of this stage.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else if (en) begin
                valid_q <= srcV;
                carry_q <= sum[CW];
                res_q   <= res_d;
            end
        end

        if (g < STAGES - 1) begin : gOps
            logic [SRCW-CW-1:0] opA_q;
            logic [SRCW-CW-1:0] opB_q;
            logic               aMsb_q;
            logic               bMsb_q;

            // Upper operand chunks not yet added, plus the operand sign bits
            // that the final stage needs for the overflow flag.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    opA_q  <= '0;
                    opB_q  <= '0;
                    aMsb_q <= 1'b0;
                    bMsb_q <= 1'b0;
                end else if (en) begin
                    opA_q  <= srcA[SRCW-1:CW];
                    opB_q  <= srcB[SRCW-1:CW];
                    aMsb_q <= srcAMsb;
                    bMsb_q <= srcBMsb;
                end
            end
        end else begin : gLast
            logic ovf_q;
            logic zero_q;

            // Flags are formed from the complete result as it enters the
            // output registers, so every output comes straight from a flop.
            // Overflow: both operands share a sign the result does not.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en) begin
                    ovf_q  <= (srcAMsb == srcBMsb) && (res_d[RESW-1] != srcAMsb);
                    zero_q <= (res_d == '0);
                end
            end
        end
    end

    assign out_valid = gStage[STAGES-1].valid_q;
    assign out       = gStage[STAGES-1].res_q;
    assign c_out     = gStage[STAGES-1].carry_q;
    assign ovf       = gStage[STAGES-1].gLast.ovf_q;
    assign zero      = gStage[STAGES-1].gLast.zero_q;

endmodule

// File: tb/tb_ysyx_22050518_pipe_addsub.sv
// tb_ysyx_22050518_pipe_addsub
// Self-checking bench for the pipelined adder/subtractor. A reference model
// computes each result with plain wide arithmetic and delays it through a
// STAGES-deep line that only moves when the pipeline is allowed to advance.
// A compare process checks the DUT against the model every cycle; directed
// cases with hand-computed values pin both the model and the DUT.
module tb_ysyx_22050518_pipe_addsub;
    localparam int W  = 64;
    localparam int ST = 4;

    localparam logic [W-1:0] ALL1 = {W{1'b1}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         c_out;
    logic         ovf;
    logic         zero;

    int vectors     = 0;
    int miscompares = 0;
    int delivered   = 0;
    bit started     = 1'b0;

    // Model delay line: expected {c_out, ovf, zero, out} per slot.
    logic         mValid [ST];
    logic [W+2:0] mData  [ST];

    ysyx_22050518_pipe_addsub #(
        .WIDTH (W),
        .STAGES(ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .c_out    (c_out),
        .ovf      (ovf),
        .zero     (zero)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference result: subtraction done as true subtraction with borrow,
    // overflow judged by whether the exact signed result fits in W bits.
    function automatic logic [W+2:0] refResult(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c, input logic s);
        logic [W:0]          full;
        logic signed [W+1:0] sa;
        logic signed [W+1:0] sb;
        logic signed [W+1:0] ideal;
        logic                v;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        if (s) begin
            full  = {1'b1, a} - {1'b0, b} - {{W{1'b0}}, c};
            ideal = sa - sb - {{(W+1){1'b0}}, c};
        end else begin
            full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            ideal = sa + sb + {{(W+1){1'b0}}, c};
        end
        v = !((ideal[W+1] == ideal[W]) && (ideal[W] == ideal[W-1]));
        return {full[W], v, (full[W-1:0] == '0), full[W-1:0]};
    endfunction

    // Operand picker biased towards the interesting corners.
    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return ALL1;
            2:       return SMIN;
            3:       return SMAX;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offers one operand set from posedge+1 and holds it until taken.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
        bit taken = 1'b0;
        in1      = a;
        in2      = b;
        c_in     = c;
        sub      = s;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !taken; t++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("accept_timeout", 72'(taken), 72'(1));
    endtask

    task automatic expectResult(input string name, input logic [W-1:0] o,
                                input logic c, input logic v, input logic z);
        checkOutput({name, "_valid"}, 72'(out_valid), 72'(1));
        checkOutput(name, 72'({c_out, ovf, zero, out}), 72'({c, v, z, o}));
    endtask

    // Model update: reset empties the line; otherwise it shifts on every
    // edge where the pipeline may advance, taking a result or a bubble.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ST; i++) begin
                mValid[i] <= 1'b0;
                mData[i]  <= '0;
            end
            started <= 1'b1;
        end else if (!mValid[ST-1] || out_ready) begin
            mValid[0] <= in_valid;
            mData[0]  <= refResult(in1, in2, c_in, sub);
            for (int i = 1; i < ST; i++) begin
                mValid[i] <= mValid[i-1];
                mData[i]  <= mData[i-1];
            end
        end
    end

    // Compare process: every cycle, mid-period, check handshake and result
    // against the model and count results that will be consumed.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("out_valid", 72'(out_valid), 72'(mValid[ST-1]));
            checkOutput("in_ready", 72'(in_ready), 72'((!mValid[ST-1]) || out_ready));
            if (mValid[ST-1])
                checkOutput("result", 72'({c_out, ovf, zero, out}), 72'(mData[ST-1]));
            if (out_valid && out_ready)
                delivered++;
        end
    end

    // Main sequence: model pins, reset, directed cases, mid-flight reset,
    // backpressure stream, then a randomized run.
    initial begin
        int ghosts;
        int d0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in1       = ALL1;
        in2       = 64'd1;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        checkOutput("model_add_wrap", 72'(refResult(ALL1, 64'd1, 1'b0, 1'b0)), 72'({1'b1, 1'b0, 1'b1, 64'd0}));
        checkOutput("model_sub_borrow", 72'(refResult(64'd5, 64'd7, 1'b0, 1'b1)), 72'({1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE}));
        checkOutput("model_add_ovf", 72'(refResult(SMAX, 64'd1, 1'b0, 1'b0)), 72'({1'b0, 1'b1, 1'b0, SMIN}));
        checkOutput("model_sub_ovf", 72'(refResult(SMIN, 64'd1, 1'b0, 1'b1)), 72'({1'b1, 1'b1, 1'b0, SMAX}));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 72'(out_valid), 72'(0));
        checkOutput("rst_in_ready", 72'(in_ready), 72'(1));
        checkOutput("rst_outputs", 72'({c_out, ovf, zero, out}), 72'(0));
        rst_n    = 1'b1;
        in_valid = 1'b0;

        applyStimulus(ALL1, 64'd1, 1'b0, 1'b0);
        repeat (ST - 1) @(posedge clk);
        #1;
        expectResult("add_wrap", 64'd0, 1'b1, 1'b0, 1'b1);

        applyStimulus(64'd5, 64'd7, 1'b0, 1'b1);
        repeat (ST - 1) @(posedge clk);
        #1;
        expectResult("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

        applyStimulus(SMAX, 64'd1, 1'b0, 1'b0);
        repeat (ST - 1) @(posedge clk);
        #1;
        expectResult("add_ovf", SMIN, 1'b0, 1'b1, 1'b0);

        applyStimulus(SMIN, 64'd1, 1'b0, 1'b1);
        repeat (ST - 1) @(posedge clk);
        #1;
        expectResult("sub_ovf", SMAX, 1'b1, 1'b1, 1'b0);

        // Three operations in flight, then a one-edge reset with an offer
        // pending; none of them may ever come out.
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(64'd1, 64'd2, 1'b0, 1'b0);
        applyStimulus(64'd3, 64'd4, 1'b1, 1'b0);
        applyStimulus(64'd9, 64'd5, 1'b0, 1'b1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in1      = 64'd100;
        in2      = 64'd200;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        checkOutput("midrst_out_valid", 72'(out_valid), 72'(0));
        ghosts = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) ghosts++;
        end
        checkOutput("midrst_ghosts", 72'(ghosts), 72'(0));

        // Six back-to-back adds; the consumer stalls for three cycles as
        // soon as the first result shows up.
        d0 = delivered;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    applyStimulus(64'(i), 64'h10, 1'b0, 1'b0);
            end
            begin
                int waitCycles = 0;
                while (!out_valid && waitCycles < 20) begin
                    @(posedge clk);
                    #1;
                    waitCycles++;
                end
                checkOutput("bp_first_valid", 72'(out_valid), 72'(1));
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #2;
                    checkOutput("bp_in_ready", 72'(in_ready), 72'(0));
                    checkOutput("bp_hold", 72'(out), 72'(64'h10));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        checkOutput("bp_delivered", 72'(delivered - d0), 72'(6));

        // Randomized traffic with random backpressure and bubbles.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in1       = pickOperand();
            in2       = pickOperand();
            c_in      = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (ST + 4) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_22050518_pipe_addsub.md
YSYX_22050518_PIPE_ADDSUB -- requirements
Module: ysyx_22050518_pipe_addsub

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 64, which sets the operand and result width in bits.
REQ-002 The block SHALL have the parameter STAGES, default 4, which sets the number of pipeline stages; WIDTH SHALL be a multiple of STAGES and STAGES SHALL be at least 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the synchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand set this cycle.
REQ-007 The block SHALL have ports in1 and in2, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port c_in, input, 1 bit: carry-in in add mode, borrow-in in subtract mode.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result ports hold a valid result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out, output, WIDTH bits: the result.
REQ-013 The block SHALL have port c_out, output, 1 bit: carry out of bit WIDTH-1.
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-015 The block SHALL have port zero, output, 1 bit: out equals 0.

Function
REQ-016 In add mode the block SHALL compute {c_out,out} = in1 + in2 + c_in, truncated to WIDTH+1 bits.
REQ-017 In subtract mode the block SHALL compute {c_out,out} = in1 + ~in2 + !c_in, so c_out=1 means no borrow.
REQ-018 ovf SHALL be 1 exactly when the MSB of in1 equals the MSB of the effective second operand (in2, or ~in2 when subtracting) and the MSB of out differs from it.
REQ-019 The carry chain SHALL be split into STAGES chunks of WIDTH/STAGES bits; stage j SHALL resolve only chunk j using the registered carry from stage j-1.
REQ-020 Higher operand chunks SHALL be carried forward in stage registers; lower result chunks SHALL be carried forward in skew registers.
REQ-021 The global advance signal SHALL be en = !out_valid || out_ready, and in_ready SHALL equal en.
REQ-022 An operand set SHALL be accepted on an edge where in_valid && in_ready; when in_valid=0 on an enabled edge, a bubble SHALL enter stage 0.
REQ-023 When en=0, all stage registers, valid bits and outputs SHALL hold their values.
REQ-024 Latency: a set accepted at edge k SHALL appear on out, c_out, ovf and zero with out_valid=1 after the STAGES-th enabled edge, counting edge k; with no stalls this is edge k+STAGES-1.
REQ-025 Throughput SHALL be one operation per cycle when out_ready stays at 1; results SHALL leave in acceptance order, with none dropped or duplicated.
REQ-026 Each result SHALL be held stable while out_valid=1 and out_ready=0.
REQ-027 Bubbles SHALL NOT be compressed; a stall freezes the whole pipeline.
REQ-028 All outputs SHALL be driven from registers, with no combinational path from in1, in2, c_in or sub to any output.
REQ-029 in_ready SHALL depend combinationally only on out_valid and out_ready.
REQ-030 When STAGES=1, the block SHALL behave as a single registered adder/subtractor with a latency of 1.

Reset
REQ-031 When rst_n=0 at a rising edge, the block SHALL clear all stage valid bits, set out_valid=0, and set out, c_out, ovf and zero to 0.
REQ-032 During reset, in_ready SHALL be 1, since out_valid=0.
REQ-033 Reset SHALL override any handshake on the same edge; operations in flight SHALL be discarded, and an offer made during reset SHALL NOT be accepted.
REQ-034 The first accept after reset SHALL be possible on the first edge with rst_n=1.

Verification (WIDTH=64, STAGES=4)
REQ-035 Reset check: hold rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, out=0, and all flags 0.
REQ-036 Add wrap: in1=0xFFFFFFFFFFFFFFFF, in2=1, c_in=0, sub=0, accepted at edge k -> at edge k+3, out=0, c_out=1, zero=1, ovf=0.
REQ-037 Subtract with borrow: in1=5, in2=7, c_in=0, sub=1 -> out=0xFFFFFFFFFFFFFFFE, c_out=0, ovf=0, zero=0.
REQ-038 Signed overflow: in1=0x7FFFFFFFFFFFFFFF, in2=1, add -> out=0x8000000000000000, ovf=1, c_out=0; also in1=0x8000000000000000, in2=1, sub -> out=0x7FFFFFFFFFFFFFFF, ovf=1.
REQ-039 Backpressure: stream 6 back-to-back adds (i + 0x10, i=0..5) with out_ready=0 for 3 cycles after the first out_valid -> in_ready=0 during the stall, out held at 0x10, and all 6 results delivered in order with none lost.
REQ-040 Reset mid-operation: 3 operations in flight, then rst_n=0 for 1 edge -> out_valid=0 on the next cycle, and none of the 3 results ever appears.
